// File: rtl/weight_seq_ctrl.sv
`default_nettype none
// ============================================================================
// weight_seq_ctrl : walks weight ROM / input buffer per neuron, drives MAC
//                   strobes and hands each neuron result to the activation stage
// Rev 1.0
// ============================================================================
module weight_seq_ctrl #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_NEURONS = 2,
    parameter int ADDR_WIDTH  = 3,
    parameter int IN_WIDTH    = 2,
    parameter int IDX_WIDTH   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hold,
    input  logic                  out_ack,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [IN_WIDTH-1:0]   in_addr,
    output logic                  mac_clr,
    output logic                  mac_valid,
    output logic                  mac_last,
    output logic                  out_req,
    output logic [IDX_WIDTH-1:0]  neuron_idx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_FETCH    = 3'd2,
        S_FLUSH    = 3'd3,
        S_WAIT_OUT = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [IN_WIDTH-1:0]   c_last_k = IN_WIDTH'(NUM_INPUTS - 1);
    localparam logic [IDX_WIDTH-1:0]  c_last_n = IDX_WIDTH'(NUM_NEURONS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_stride = ADDR_WIDTH'(NUM_INPUTS);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [IDX_WIDTH-1:0]    neuron_q, neuron_d;
    logic                    rom_en_q, rom_en_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [IN_WIDTH-1:0]     in_addr_q, in_addr_d;
    logic                    mac_clr_q, mac_clr_d;
    logic                    mac_valid_q, mac_valid_d;
    logic                    mac_last_q, mac_last_d;
    logic                    out_req_q, out_req_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    w_last_issued;

    // The address registers double as the issue counter: in_addr_q is the k
    // most recently issued, and stays frozen while hold stalls the walk.
    assign w_last_issued = rom_en_q && (in_addr_q == c_last_k);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        neuron_d    = neuron_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        in_addr_d   = in_addr_q;
        mac_valid_d = rom_en_q;
        mac_last_d  = w_last_issued;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CLEAR;
                    neuron_d = '0;
                    base_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d    = S_FETCH;
                rom_en_d   = 1'b1;
                rom_addr_d = base_q;
                in_addr_d  = '0;
            end
            S_FETCH: begin
                if (w_last_issued) begin
                    state_d = S_FLUSH;
                end else if (!hold) begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
                    in_addr_d  = in_addr_q + IN_WIDTH'(1);
                end
            end
            S_FLUSH: begin
                state_d = S_WAIT_OUT;
            end
            S_WAIT_OUT: begin
                if (out_ack) begin
                    if (neuron_q == c_last_n) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_CLEAR;
                        neuron_d = neuron_q + IDX_WIDTH'(1);
                        base_d   = base_q + c_stride;
                    end
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                neuron_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mac_clr_d = (state_d == S_CLEAR);
        out_req_d = (state_d == S_WAIT_OUT);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            neuron_q    <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            in_addr_q   <= '0;
            mac_clr_q   <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_last_q  <= 1'b0;
            out_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            neuron_q    <= neuron_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            in_addr_q   <= in_addr_d;
            mac_clr_q   <= mac_clr_d;
            mac_valid_q <= mac_valid_d;
            mac_last_q  <= mac_last_d;
            out_req_q   <= out_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign in_addr    = in_addr_q;
    assign mac_clr    = mac_clr_q;
    assign mac_valid  = mac_valid_q;
    assign mac_last   = mac_last_q;
    assign out_req    = out_req_q;
    assign neuron_idx = neuron_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire
